// File: rtl/cpu_log_emitter.sv
// Serializes one retire event per handshake into cpu_checker trace text,
// one ASCII char per clock: "^<time>@<pc>: $<grf> <= <data>#" or "*<addr>".
module cpu_log_emitter #(
    parameter logic [7:0] IDLE_CHAR  = 8'h00,
    parameter int         GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_type,
    input  logic [15:0] req_time,
    input  logic [31:0] req_pc,
    input  logic [4:0]  req_grf,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic [7:0]  out_char,
    output logic        out_valid,
    output logic        rec_done
);

    typedef enum logic [4:0] {
        S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_SEL,
        S_REG, S_ADDR, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH, S_GAP
    } state_t;

    state_t      state;
    logic        is_mem;
    logic [15:0] t_buf;
    logic [1:0]  t_cnt;
    logic [7:0]  g_buf;
    logic        g_cnt;
    logic [31:0] pc_sr;
    logic [31:0] addr_sr;
    logic [31:0] data_sr;
    logic [2:0]  nib_cnt;
    logic [3:0]  gap_cnt;

    logic [13:0] t_clamp;
    logic [15:0] t_digits;
    logic [1:0]  t_last;
    logic [15:0] t_left;
    logic [7:0]  g_digits;
    logic        g_last;
    logic [7:0]  g_left;

    // Digits are left-aligned at capture so emission only shifts out the top.
    always_comb begin
        t_clamp  = (req_time > 16'd9999) ? 14'd9999 : req_time[13:0];
        t_digits = {4'(t_clamp / 14'd1000),
                    4'((t_clamp / 14'd100) % 14'd10),
                    4'((t_clamp / 14'd10) % 14'd10),
                    4'(t_clamp % 14'd10)};
        if (t_clamp >= 14'd1000)
            t_last = 2'd3;
        else if (t_clamp >= 14'd100)
            t_last = 2'd2;
        else if (t_clamp >= 14'd10)
            t_last = 2'd1;
        else
            t_last = 2'd0;
        t_left   = t_digits << (4'd12 - {t_last, 2'b00});
        g_digits = {4'(req_grf / 5'd10), 4'(req_grf % 5'd10)};
        g_last   = (req_grf >= 5'd10);
        g_left   = g_last ? g_digits : {g_digits[3:0], 4'h0};
    end

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] n);
        return 8'h30 + {4'h0, n};
    endfunction

    assign req_ready = (state == S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            is_mem    <= 1'b0;
            t_buf     <= '0;
            t_cnt     <= '0;
            g_buf     <= '0;
            g_cnt     <= 1'b0;
            pc_sr     <= '0;
            addr_sr   <= '0;
            data_sr   <= '0;
            nib_cnt   <= '0;
            gap_cnt   <= '0;
            out_char  <= IDLE_CHAR;
            out_valid <= 1'b0;
            rec_done  <= 1'b0;
        end else begin
            rec_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    out_char  <= IDLE_CHAR;
                    out_valid <= 1'b0;
                    if (req_valid) begin
                        is_mem    <= req_type;
                        t_buf     <= t_left;
                        t_cnt     <= t_last;
                        g_buf     <= g_left;
                        g_cnt     <= g_last;
                        pc_sr     <= req_pc;
                        addr_sr   <= req_addr;
                        data_sr   <= req_data;
                        out_char  <= 8'h5e;
                        out_valid <= 1'b1;
                        state     <= S_CARET;
                    end
                end
                S_CARET: begin
                    out_char <= dec_char(t_buf[15:12]);
                    t_buf    <= t_buf << 4;
                    state    <= S_TIME;
                end
                S_TIME: begin
                    if (t_cnt == 2'd0) begin
                        out_char <= 8'h40;
                        state    <= S_AT;
                    end else begin
                        out_char <= dec_char(t_buf[15:12]);
                        t_buf    <= t_buf << 4;
                        t_cnt    <= t_cnt - 2'd1;
                    end
                end
                S_AT: begin
                    out_char <= hex_char(pc_sr[31:28]);
                    pc_sr    <= pc_sr << 4;
                    nib_cnt  <= 3'd7;
                    state    <= S_PC;
                end
                S_PC: begin
                    if (nib_cnt == 3'd0) begin
                        out_char <= 8'h3a;
                        state    <= S_COLON;
                    end else begin
                        out_char <= hex_char(pc_sr[31:28]);
                        pc_sr    <= pc_sr << 4;
                        nib_cnt  <= nib_cnt - 3'd1;
                    end
                end
                S_COLON: begin
                    out_char <= 8'h20;
                    state    <= S_SP1;
                end
                S_SP1: begin
                    out_char <= is_mem ? 8'h2a : 8'h24;
                    state    <= S_SEL;
                end
                S_SEL: begin
                    if (is_mem) begin
                        out_char <= hex_char(addr_sr[31:28]);
                        addr_sr  <= addr_sr << 4;
                        nib_cnt  <= 3'd7;
                        state    <= S_ADDR;
                    end else begin
                        out_char <= dec_char(g_buf[7:4]);
                        g_buf    <= g_buf << 4;
                        state    <= S_REG;
                    end
                end
                S_REG: begin
                    if (!g_cnt) begin
                        out_char <= 8'h20;
                        state    <= S_SP2;
                    end else begin
                        out_char <= dec_char(g_buf[7:4]);
                        g_cnt    <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (nib_cnt == 3'd0) begin
                        out_char <= 8'h20;
                        state    <= S_SP2;
                    end else begin
                        out_char <= hex_char(addr_sr[31:28]);
                        addr_sr  <= addr_sr << 4;
                        nib_cnt  <= nib_cnt - 3'd1;
                    end
                end
                S_SP2: begin
                    out_char <= 8'h3c;
                    state    <= S_LT;
                end
                S_LT: begin
                    out_char <= 8'h3d;
                    state    <= S_EQ;
                end
                S_EQ: begin
                    out_char <= 8'h20;
                    state    <= S_SP3;
                end
                S_SP3: begin
                    out_char <= hex_char(data_sr[31:28]);
                    data_sr  <= data_sr << 4;
                    nib_cnt  <= 3'd7;
                    state    <= S_DATA;
                end
                S_DATA: begin
                    if (nib_cnt == 3'd0) begin
                        out_char <= 8'h23;
                        rec_done <= 1'b1;
                        state    <= S_HASH;
                    end else begin
                        out_char <= hex_char(data_sr[31:28]);
                        data_sr  <= data_sr << 4;
                        nib_cnt  <= nib_cnt - 3'd1;
                    end
                end
                S_HASH: begin
                    out_char  <= IDLE_CHAR;
                    out_valid <= 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= 4'(GAP_CYCLES - 1);
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    out_char  <= IDLE_CHAR;
                    out_valid <= 1'b0;
                    if (gap_cnt == 4'd0)
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt - 4'd1;
                end
                default: begin
                    out_char  <= IDLE_CHAR;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_log_emitter.sv
// Directed bench for cpu_log_emitter: records are rebuilt from the char
// stream and compared with hand-written trace strings.
module tb_cpu_log_emitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_type;
    logic [15:0] req_time;
    logic [31:0] req_pc;
    logic [4:0]  req_grf;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [7:0]  out_char;
    logic        out_valid;
    logic        rec_done;

    int errors = 0;
    int checks = 0;

    string recs[$];
    string cur = "";
    int    done_cnt = 0;
    int    stream_bad = 0;

    always #5 clk = ~clk;

    cpu_log_emitter #(
        .IDLE_CHAR (8'h00),
        .GAP_CYCLES(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_type (req_type),
        .req_time (req_time),
        .req_pc   (req_pc),
        .req_grf  (req_grf),
        .req_addr (req_addr),
        .req_data (req_data),
        .out_char (out_char),
        .out_valid(out_valid),
        .rec_done (rec_done)
    );

    // Rebuilds records from the stream; a reset drops any partial text.
    always @(negedge clk) begin
        if (!reset) begin
            cur = "";
        end else begin
            if (out_valid)
                cur = $sformatf("%s%c", cur, out_char);
            else if (out_char !== 8'h00)
                stream_bad++;
            if (rec_done) begin
                if (out_char !== 8'h23 || !out_valid)
                    stream_bad++;
                recs.push_back(cur);
                cur = "";
                done_cnt++;
            end
        end
    end

    task automatic scramble();
        req_type = ~req_type;
        req_time = 16'h5a5a;
        req_pc   = 32'hffff_ffff;
        req_grf  = 5'd17;
        req_addr = 32'h7777_7777;
        req_data = 32'h0bad_0bad;
    endtask

    task automatic send(input logic t, input logic [15:0] tm,
                        input logic [31:0] pc, input logic [4:0] g,
                        input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            errors++;
            $display("FAIL send_ready: req_ready=%0b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_type  = t;
        req_time  = tm;
        req_pc    = pc;
        req_grf   = g;
        req_addr  = a;
        req_data  = d;
        @(negedge clk);
        req_valid = 1'b0;
        scramble();
    endtask

    task automatic get_rec(output string s, output bit ok);
        int n = 0;
        while (recs.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (recs.size() != 0);
        s  = ok ? recs.pop_front() : "<timeout>";
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 1'b0;
        req_type  = 1'b0;
        req_time  = '0;
        req_pc    = '0;
        req_grf   = '0;
        req_addr  = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_char !== 8'h00 || out_valid !== 1'b0 || rec_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: char=%h valid=%b done=%b required 00 0 0",
                     out_char, out_valid, rec_done);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_type0();
        string s;
        bit    ok;
        int    d0 = done_cnt;
        send(1'b0, 16'd5, 32'h3000, 5'd2, 32'h0, 32'h1234_5678);
        checks++;
        if (out_char !== 8'h5e || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL t1_caret: char=%h valid=%b required 5e 1", out_char, out_valid);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL t1_busy: req_ready=%b required 0", req_ready);
        end
        get_rec(s, ok);
        checks++;
        if (!ok || s != "^5@00003000: $2 <= 12345678#") begin
            errors++;
            $display("FAIL t1_text: got \"%s\" required \"^5@00003000: $2 <= 12345678#\"", s);
        end
        checks++;
        if (s.len() != 28 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL t1_len: len=%0d dones=%0d required 28 1", s.len(), done_cnt - d0);
        end
    endtask

    task automatic test_type1();
        string s;
        bit    ok;
        send(1'b1, 16'd1234, 32'h3004, 5'd0, 32'h10, 32'hdead_beef);
        get_rec(s, ok);
        checks++;
        if (!ok || s != "^1234@00003004: *00000010 <= deadbeef#") begin
            errors++;
            $display("FAIL t2_text: got \"%s\" required \"^1234@00003004: *00000010 <= deadbeef#\"", s);
        end
        checks++;
        if (s.len() != 38) begin
            errors++;
            $display("FAIL t2_len: len=%0d required 38", s.len());
        end
    endtask

    task automatic test_boundaries();
        string s;
        bit    ok;
        send(1'b0, 16'd0, 32'h0, 5'd31, 32'h0, 32'hffff_ffff);
        get_rec(s, ok);
        checks++;
        if (!ok || s != "^0@00000000: $31 <= ffffffff#") begin
            errors++;
            $display("FAIL t3_zero_time: got \"%s\" required \"^0@00000000: $31 <= ffffffff#\"", s);
        end
        send(1'b0, 16'd65535, 32'h3008, 5'd0, 32'h0, 32'h8000_0001);
        get_rec(s, ok);
        checks++;
        if (!ok || s != "^9999@00003008: $0 <= 80000001#") begin
            errors++;
            $display("FAIL t3_clamp: got \"%s\" required \"^9999@00003008: $0 <= 80000001#\"", s);
        end
        send(1'b1, 16'd10, 32'h0000_000a, 5'd9, 32'hffff_ffff, 32'h0a0b_0c0d);
        get_rec(s, ok);
        checks++;
        if (!ok || s != "^10@0000000a: *ffffffff <= 0a0b0c0d#") begin
            errors++;
            $display("FAIL t3_two_digit: got \"%s\" required \"^10@0000000a: *ffffffff <= 0a0b0c0d#\"", s);
        end
    endtask

    task automatic test_back_to_back();
        logic        ev_t[3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] ev_tm[3] = '{16'd7, 16'd42, 16'd100};
        logic [31:0] ev_pc[3] = '{32'h100, 32'h104, 32'h108};
        logic [4:0]  ev_g[3] = '{5'd1, 5'd3, 5'd10};
        logic [31:0] ev_a[3] = '{32'h0, 32'h20, 32'h0};
        logic [31:0] ev_d[3] = '{32'h1111_1111, 32'hcafe_f00d, 32'h0};
        string       exp[3] = '{"^7@00000100: $1 <= 11111111#",
                                "^42@00000104: *00000020 <= cafef00d#",
                                "^100@00000108: $10 <= 00000000#"};
        logic [7:0]  lc[120];
        logic        lv[120];
        int          acc = 0;
        bit          acc_prev = 1'b0;
        int          rdy = 0;
        int          hashes = 0;
        string       s;
        bit          ok;
        int          n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_type  = ev_t[0];
        req_time  = ev_tm[0];
        req_pc    = ev_pc[0];
        req_grf   = ev_g[0];
        req_addr  = ev_a[0];
        req_data  = ev_d[0];
        acc_prev  = req_ready;
        rdy       = req_ready ? 1 : 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (acc_prev) begin
                acc++;
                acc_prev = 1'b0;
                if (acc < 3) begin
                    req_type = ev_t[acc];
                    req_time = ev_tm[acc];
                    req_pc   = ev_pc[acc];
                    req_grf  = ev_g[acc];
                    req_addr = ev_a[acc];
                    req_data = ev_d[acc];
                end else begin
                    req_valid = 1'b0;
                    scramble();
                end
            end
            lc[c] = out_char;
            lv[c] = out_valid;
            if (req_ready && req_valid) begin
                acc_prev = 1'b1;
                rdy++;
            end
        end
        checks++;
        if (rdy != 3) begin
            errors++;
            $display("FAIL t4_ready_cycles: got %0d required 3", rdy);
        end
        for (int i = 0; i + 3 < 120; i++) begin
            if (lv[i] && lc[i] == 8'h23) begin
                hashes++;
                if (hashes < 3) begin
                    checks++;
                    if (lv[i+1] || lv[i+2] || lc[i+1] !== 8'h00 || lc[i+2] !== 8'h00 ||
                        !lv[i+3] || lc[i+3] !== 8'h5e) begin
                        errors++;
                        $display("FAIL t4_gap%0d: after # got %h %h %h required 00 00 5e",
                                 hashes, lc[i+1], lc[i+2], lc[i+3]);
                    end
                end
            end
        end
        checks++;
        if (hashes != 3) begin
            errors++;
            $display("FAIL t4_hash_count: got %0d required 3", hashes);
        end
        for (int k = 0; k < 3; k++) begin
            get_rec(s, ok);
            checks++;
            if (!ok || s != exp[k]) begin
                errors++;
                $display("FAIL t4_rec%0d: got \"%s\" required \"%s\"", k, s, exp[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        string s;
        bit    ok;
        int    n = 0;
        send(1'b0, 16'd5, 32'h1234_5678, 5'd4, 32'h0, 32'h5555_aaaa);
        while (out_char !== 8'h34 && n < 50) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_char !== 8'h00 || req_ready !== 1'b1 || rec_done !== 1'b0) begin
            errors++;
            $display("FAIL t5_abort: valid=%b char=%h ready=%b done=%b required 0 00 1 0",
                     out_valid, out_char, req_ready, rec_done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (recs.size() != 0) begin
            errors++;
            $display("FAIL t5_no_tail: records=%0d required 0", recs.size());
            recs.delete();
        end
        send(1'b1, 16'd77, 32'h0040_0000, 5'd0, 32'h1000_0004, 32'h0000_00ff);
        get_rec(s, ok);
        checks++;
        if (!ok || s != "^77@00400000: *10000004 <= 000000ff#") begin
            errors++;
            $display("FAIL t5_after: got \"%s\" required \"^77@00400000: *10000004 <= 000000ff#\"", s);
        end
    endtask

    task automatic test_lowercase_busy();
        string s;
        bit    ok;
        int    d0 = done_cnt;
        send(1'b0, 16'd3, 32'hABCD_EF00, 5'd5, 32'h0, 32'h9abc_def0);
        repeat (5) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL t6_busy_ready: req_ready=%b required 0", req_ready);
        end
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        get_rec(s, ok);
        checks++;
        if (!ok || s != "^3@abcdef00: $5 <= 9abcdef0#") begin
            errors++;
            $display("FAIL t6_text: got \"%s\" required \"^3@abcdef00: $5 <= 9abcdef0#\"", s);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || recs.size() != 0) begin
            errors++;
            $display("FAIL t6_no_extra: records=%0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_stream_integrity();
        checks++;
        if (stream_bad != 0) begin
            errors++;
            $display("FAIL stream_idle_hash: violations=%0d required 0", stream_bad);
        end
    endtask

    initial begin
        test_reset();
        test_type0();
        test_type1();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        test_lowercase_busy();
        test_stream_integrity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
